// File: rtl/srambank_param.sv
// srambank_param: banked single-port SRAM with byte mask, optional output stage, clear-on-reset sequencer; ports clk/reset, ADDRESS/wd/wmask/banksel/read/write in, dataout/rvalid/busy/err_rw out
module srambank_param #(
  parameter int WORDS = 1024,
  parameter int WIDTH = 32,
  parameter int NBANKS = 4,
  parameter int BYTEW = 8,
  parameter int OUTREG = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            ADDRESS,
  input  logic [WIDTH-1:0]         wd,
  input  logic [WIDTH/BYTEW-1:0]   wmask,
  input  logic                     banksel,
  input  logic                     read,
  input  logic                     write,
  output logic [WIDTH-1:0]         dataout,
  output logic                     rvalid,
  output logic                     busy,
  output logic                     err_rw
);
  localparam int LANES = WIDTH / BYTEW;
  localparam int ROWS = WORDS / NBANKS;
  localparam int RS = $clog2(ROWS);
  localparam int RW = RS > 0 ? RS : 1;
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q;
  logic [RW-1:0] cnt_q, row;
  logic [BW-1:0] bank;
  logic acc, wr, rd, pv_q, rvalid_q, err_q;
  logic [WIDTH-1:0] rdata [NBANKS];
  logic [WIDTH-1:0] pd_q, dout_q;
  assign row = RS > 0 ? RW'(ADDRESS) : '0;
  assign bank = NBANKS > 1 ? BW'(ADDRESS >> RS) : '0;
  assign busy = state_q == CLEAR;
  assign acc = !reset && !busy && banksel;
  assign wr = acc && write;
  assign rd = acc && read && !write;
  assign dataout = dout_q;
  assign rvalid = rvalid_q;
  assign err_rw = err_q;
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [ROWS];
    always_ff @(posedge clk)
      if (busy) mem[cnt_q] <= '0;
      else if (wr && bank == BW'(b))
        for (int i = 0; i < LANES; i++)
          if (wmask[i]) mem[row][i*BYTEW +: BYTEW] <= wd[i*BYTEW +: BYTEW];
    assign rdata[b] = mem[row];
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt_q <= '0;
    end else if (busy) begin
      state_q <= cnt_q == RW'(ROWS - 1) ? IDLE : CLEAR;
      cnt_q <= cnt_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (reset) begin
      pv_q <= 1'b0;
      pd_q <= '0;
      rvalid_q <= 1'b0;
      dout_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= acc && read && write;
      pv_q <= rd;
      pd_q <= rd ? rdata[bank] : pd_q;
      if (OUTREG != 0) begin
        rvalid_q <= pv_q;
        dout_q <= pv_q ? pd_q : dout_q;
      end else begin
        rvalid_q <= rd;
        dout_q <= rd ? rdata[bank] : dout_q;
      end
    end
endmodule

// File: tb/tb_srambank_param.sv
// tb_srambank_param: table and scoreboard bench for srambank_param in three configurations
module tb_srambank_param;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [9:0] addr = '0;
  logic [31:0] wd = '0, dout0, dout1;
  logic [3:0] wm = '0;
  logic bs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic rv0, rv1, busy0, busy1, err0, err1;
  logic [5:0] a2 = '0;
  logic [15:0] wd2 = '0, dout2;
  logic [1:0] wm2 = '0;
  logic bs2 = 1'b0, rd2 = 1'b0, wr2 = 1'b0, rv2, busy2, err2;
  int total = 0, bad = 0, cyc = 0, n0 = 0, n1 = 0;
  logic cnt_en = 1'b0;
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q0[$], q1[$];
  typedef struct {logic [9:0] a; logic [31:0] d; logic [3:0] m; logic r, w; logic [31:0] e;} vec_t;
  vec_t tv[16];
  srambank_param d0 (
    .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wm), .banksel(bs), .read(rd), .write(wr),
    .dataout(dout0), .rvalid(rv0), .busy(busy0), .err_rw(err0));
  srambank_param #(.OUTREG(1)) d1 (
    .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wm), .banksel(bs), .read(rd), .write(wr),
    .dataout(dout1), .rvalid(rv1), .busy(busy1), .err_rw(err1));
  srambank_param #(.WORDS(64), .NBANKS(1), .WIDTH(16), .CLEAR_ON_RESET(0)) d2 (
    .clk(clk), .reset(reset), .ADDRESS(a2), .wd(wd2), .wmask(wm2), .banksel(bs2), .read(rd2), .write(wr2),
    .dataout(dout2), .rvalid(rv2), .busy(busy2), .err_rw(err2));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (cnt_en) begin
      n0 += busy0 ? 1 : 0;
      n1 += busy1 ? 1 : 0;
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin : mon
      exp_t e;
      if (rv0) begin
        if (q0.size() == 0) chk("rv0 unexpected", {31'd0, rv0}, 32'd0);
        else begin
          e = q0.pop_front();
          chk("rd0 data", dout0, e.d);
          chk("rd0 cycle", cyc, e.c);
        end
      end
      if (rv1) begin
        if (q1.size() == 0) chk("rv1 unexpected", {31'd0, rv1}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("rd1 data", dout1, e.d);
          chk("rd1 cycle", cyc, e.c);
        end
      end
    end
  task automatic issue(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic b, input logic r, input logic w, input logic [1:0] p, input logic [31:0] e);
    exp_t x;
    addr = a; wd = d; wm = m; bs = b; rd = r; wr = w;
    x.d = e;
    x.c = cyc + 1;
    if (p[0]) q0.push_back(x);
    x.c = cyc + 2;
    if (p[1]) q1.push_back(x);
    @(posedge clk); #1;
    bs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic rst_pulse;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{10'h000, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0};
    tv[1]  = '{10'h0FF, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0};
    tv[2]  = '{10'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0};
    tv[3]  = '{10'h3FF, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0};
    tv[4]  = '{10'h3FF, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0};
    tv[5]  = '{10'h3FF, 32'h11223344, 4'h5, 1'b0, 1'b1, 32'h0};
    tv[6]  = '{10'h3FF, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDE22BE44};
    tv[7]  = '{10'h001, 32'h0000000A, 4'hF, 1'b0, 1'b1, 32'h0};
    tv[8]  = '{10'h101, 32'h0000000B, 4'hF, 1'b0, 1'b1, 32'h0};
    tv[9]  = '{10'h001, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000000A};
    tv[10] = '{10'h101, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000000B};
    tv[11] = '{10'h002, 32'h12345678, 4'h0, 1'b0, 1'b1, 32'h0};
    tv[12] = '{10'h002, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0};
    tv[13] = '{10'h203, 32'hAABBCCDD, 4'h8, 1'b0, 1'b1, 32'h0};
    tv[14] = '{10'h203, 32'h0, 4'h0, 1'b1, 1'b0, 32'hAA000000};
    tv[15] = '{10'h3FF, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDE22BE44};
    @(posedge clk); #1;
    rst_pulse;
    cnt_en = 1'b1;
    @(negedge clk);
    chk("reset dout0", dout0, 32'h0);
    chk("reset dout1", dout1, 32'h0);
    chk("reset rv0", rv0, 32'h0);
    chk("reset rv1", rv1, 32'h0);
    chk("reset err0", err0, 32'h0);
    chk("reset busy0", busy0, 32'h1);
    chk("reset busy1", busy1, 32'h1);
    chk("reset busy2", busy2, 32'h0);
    chk("reset rv2", rv2, 32'h0);
    chk("reset err2", err2, 32'h0);
    idle(300);
    cnt_en = 1'b0;
    chk("clear cycles d0", n0, 256);
    chk("clear cycles d1", n1, 256);
    for (int i = 0; i < 16; i++)
      issue(tv[i].a, tv[i].d, tv[i].m, 1'b1, tv[i].r, tv[i].w, tv[i].r ? 2'b11 : 2'b00, tv[i].e);
    idle(4);
    issue(10'h010, 32'h55, 4'hF, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0);
    @(negedge clk);
    chk("collision err0", err0, 32'h1);
    chk("collision err1", err1, 32'h1);
    chk("collision rv0", rv0, 32'h0);
    chk("collision dout0", dout0, 32'hDE22BE44);
    chk("collision dout1", dout1, 32'hDE22BE44);
    idle(1);
    @(negedge clk);
    chk("err0 one cycle", err0, 32'h0);
    chk("err1 one cycle", err1, 32'h0);
    idle(1);
    issue(10'h010, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h55);
    issue(10'h3FF, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
    idle(3);
    chk("banksel0 dout0", dout0, 32'h55);
    chk("banksel0 dout1", dout1, 32'h55);
    issue(10'h3FF, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
    rst_pulse;
    idle(100);
    rst_pulse;
    n0 = 0;
    n1 = 0;
    cnt_en = 1'b1;
    issue(10'h005, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0);
    issue(10'h005, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
    idle(300);
    cnt_en = 1'b0;
    chk("reclear cycles d0", n0, 256);
    chk("reclear cycles d1", n1, 256);
    chk("flushed dout0", dout0, 32'h0);
    chk("flushed dout1", dout1, 32'h0);
    issue(10'h005, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h0);
    issue(10'h3FF, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h0);
    idle(4);
    a2 = 6'd63; wd2 = 16'hBEEF; wm2 = 2'b11; bs2 = 1'b1; wr2 = 1'b1;
    @(posedge clk); #1;
    wr2 = 1'b0; rd2 = 1'b1;
    @(posedge clk); #1;
    rd2 = 1'b0; bs2 = 1'b0;
    @(negedge clk);
    chk("d2 rv full", rv2, 32'h1);
    chk("d2 data full", dout2, 32'h0000BEEF);
    chk("d2 busy", busy2, 32'h0);
    idle(1);
    wd2 = 16'h1234; wm2 = 2'b10; bs2 = 1'b1; wr2 = 1'b1;
    @(posedge clk); #1;
    wr2 = 1'b0; rd2 = 1'b1;
    @(posedge clk); #1;
    rd2 = 1'b0; bs2 = 1'b0;
    @(negedge clk);
    chk("d2 rv mask", rv2, 32'h1);
    chk("d2 data mask", dout2, 32'h000012EF);
    idle(1);
    @(negedge clk);
    chk("d2 rv pulse", rv2, 32'h0);
    chk("d2 data hold", dout2, 32'h000012EF);
    chk("q0 drained", q0.size(), 32'h0);
    chk("q1 drained", q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
